layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Sequences one fully-connected layer through a single shared serial multiply-accumulate datapath: one neuron at a time, one input per cycle. Fetches input activations, weights and biases from external synchronous memories, accumulates, adds bias, saturates to signed 8-bit and streams each neuron's result out with an index. Sits between the input/activation buffer and the next layer's buffer, replacing the fully parallel per-neuron datapath when area matters more than latency.

## Interface
- `NUM_INPUTS`, default 784: inputs per neuron (N).
- `NUM_NEURONS`, default 16: neurons in the layer (M).
- `RESOLUTION`, default 8: signed data/weight/bias width.
- `clk` in 1: clock; one clock domain, everything on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request to run the layer; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive of the `done` cycle.
- `done` out 1: one-cycle pulse after the last neuron's result.
- `in_addr` out clog2(N): input activation read address.
- `in_data` in RESOLUTION: signed activation; valid one cycle after `in_addr`.
- `w_addr` out clog2(N*M): weight address, computed as neuron*N + input.
- `w_data` in RESOLUTION: signed weight; one-cycle read latency.
- `b_addr` out clog2(M): bias address, computed as neuron index.
- `b_data` in RESOLUTION: signed bias; one-cycle read latency.
- `out_valid` out 1: one-cycle strobe; result is valid.
- `out_index` out clog2(M): neuron index of the result.
- `out_data` out RESOLUTION: saturated signed result.

## Operation
- FSM states:
  - IDLE -> MAC: on `start`; clears neuron index and input index.
  - MAC: presents input index i = 0..N-1, one per cycle. After i = N-1, goes to DRAIN.
  - DRAIN -> WRITE: one cycle; accumulates the last product.
  - WRITE: if neuron < M-1, increments neuron, clears input index and goes to MAC; otherwise goes to DONE.
  - DONE -> IDLE: one cycle.
- Accumulator:
  - Clears on entry to MAC for each neuron.
  - In the cycle after each address, adds the product in_data*w_data: signed 2*RES bits, sign-extended.
  - Width is 2*RES + clog2(N) + 1 bits, so overflow cannot occur.
- Bias:
  - Added sign-extended, unshifted, in the same fixed-point scale as all other neuron arithmetic.
  - Sampled from `b_data` during DRAIN; `b_addr` is held constant for the whole neuron.
- Saturation: z > 127 gives 127; z < -128 gives -128; otherwise z[RES-1:0].
- WRITE cycle: `out_valid` = 1, `out_index` = neuron, `out_data` = the saturated value. All three are registered.
- `start` is ignored when not in IDLE; it is not queued.
- `start` held high through DONE starts a new run from the IDLE cycle that follows.

## Timing
- Reset values:
  - FSM = IDLE; accumulator and both indices = 0.
  - `busy`, `done`, `out_valid` = 0.
  - `in_addr`, `w_addr`, `b_addr`, `out_index`, `out_data` = 0.
- Reset mid-run: takes effect at the next edge. No further `out_valid` and no `done` for the aborted run.
- Cycle numbering: call the edge that samples `start` in IDLE "edge 0"; cycle k is the cycle after edge k.
  - Neuron n occupies cycles 1 + n*(N+2) through (n+1)*(N+2).
  - Its `out_valid` is in cycle (n+1)*(N+2).
  - `done` is in cycle 1 + M*(N+2).
  - IDLE is re-entered in the cycle after `done`.
- Throughput: one result per N+2 cycles; back-to-back neurons have no gap.
- Memories must be synchronous with exactly one cycle of read latency. The block has no stall input.

## Structure
- Shared package `nn_pkg`:
  - RESOLUTION, MAX_8 = 127, MIN_8 = -128.
  - The FSM state encoding.
  - A `saturate` function from accumulator width to RESOLUTION.
- Sub-module `mac_accumulator`: clear, enable, signed a/b, bias add and saturation output, parameterised on RESOLUTION and N.
- The FSM and address generation stay in `layer_sequencer`.

## Test plan
All scenarios use N=4, M=2.
- Basic run: all inputs 10, all weights 3, bias 5.
  - Expect out_valid in cycles 6 and 12 with data 125 and indices 0 and 1.
  - Expect done in cycle 13.
- Positive saturation: inputs 10, neuron 1 weights 4, bias 5 (sum 165). Expect index 1 to give 127.
- Negative saturation: inputs 100, weights -100, bias 0 (sum -40000). Expect -128.
- Negative bias in range: inputs 2, weights 1, bias -20 (sum -12). Expect -12 exactly.
- Start while busy: pulse `start` in cycle 3. Expect results identical to the basic run and exactly one `done`.
- Reset mid-run: assert `reset` in cycle 8.
  - Expect all outputs 0 on the next cycle and no `done`.
  - A following `start` gives the basic-run results.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the serial neural-layer datapath: data width,
// saturation bounds, sequencer state encoding and the saturate helper.
package nn_pkg;

  localparam int RESOLUTION = 8;
  localparam int MAX_8      = 127;
  localparam int MIN_8      = -128;

  // Widest accumulator the saturate helper accepts; callers sign-extend into it.
  localparam int SAT_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic logic signed [RESOLUTION-1:0] saturate(input logic signed [SAT_W-1:0] z);
    if (z > SAT_W'(MAX_8)) begin
      return RESOLUTION'(MAX_8);
    end else if (z < SAT_W'(MIN_8)) begin
      return RESOLUTION'(MIN_8);
    end else begin
      return z[RESOLUTION-1:0];
    end
  endfunction

endpackage

// File: rtl/mac_accumulator.sv
// Serial signed multiply-accumulate with bias add and saturated 8-bit result.
// The accumulator is wide enough that NUM_INPUTS full-scale products never overflow.
module mac_accumulator
  import nn_pkg::*;
#(
  parameter int  RESOLUTION = 8,
  parameter int  NUM_INPUTS = 784,
  localparam int ACC_W      = 2 * RESOLUTION + $clog2(NUM_INPUTS) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         enable,
  input  logic signed [RESOLUTION-1:0] a,
  input  logic signed [RESOLUTION-1:0] b,
  input  logic signed [RESOLUTION-1:0] bias,
  output logic signed [RESOLUTION-1:0] result
);

  logic signed [2*RESOLUTION-1:0] prod;
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        acc_next;
  logic signed [ACC_W-1:0]        total;

  assign prod     = (2*RESOLUTION)'(a) * (2*RESOLUTION)'(b);
  assign acc_next = acc + ACC_W'(prod);

  // The result folds in the product currently on the bus, so it is only
  // meaningful in the drain cycle when that product is the neuron's last.
  assign total  = acc_next + ACC_W'(bias);
  assign result = saturate(SAT_W'(total));

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Runs one fully-connected layer through a single shared MAC: one neuron at a
// time, one input per cycle, against one-cycle-latency external memories.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int  NUM_INPUTS  = 784,
  parameter int  NUM_NEURONS = 16,
  parameter int  RESOLUTION  = 8,
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int WW = (NUM_INPUTS * NUM_NEURONS > 1) ? $clog2(NUM_INPUTS * NUM_NEURONS) : 1,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [IW-1:0]                in_addr,
  input  logic signed [RESOLUTION-1:0] in_data,
  output logic [WW-1:0]                w_addr,
  input  logic signed [RESOLUTION-1:0] w_data,
  output logic [NW-1:0]                b_addr,
  input  logic signed [RESOLUTION-1:0] b_data,
  output logic                         out_valid,
  output logic [NW-1:0]                out_index,
  output logic signed [RESOLUTION-1:0] out_data
);

  state_t                         state;
  state_t                         next_state;
  logic [IW-1:0]                  in_idx;
  logic [WW-1:0]                  w_idx;
  logic [NW-1:0]                  nrn;
  logic                           prod_valid;
  logic                           acc_clear;
  logic                           last_input;
  logic                           last_neuron;
  logic signed [RESOLUTION-1:0]   mac_result;

  assign last_input  = (in_idx == IW'(NUM_INPUTS - 1));
  assign last_neuron = (nrn == NW'(NUM_NEURONS - 1));

  assign in_addr = in_idx;
  assign w_addr  = w_idx;
  assign b_addr  = nrn;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    acc_clear  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_MAC;
          acc_clear  = 1'b1;
        end
      end
      S_MAC: begin
        if (last_input) begin
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: next_state = S_WRITE;
      S_WRITE: begin
        if (last_neuron) begin
          next_state = S_DONE;
        end else begin
          next_state = S_MAC;
          acc_clear  = 1'b1;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Weight addresses are contiguous across neurons (neuron*N + i), so a single
  // running counter replaces the multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_idx     <= '0;
      w_idx      <= '0;
      nrn        <= '0;
      prod_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_data   <= '0;
    end else begin
      // Memory data lags its address by one cycle, so products trail MAC by one.
      prod_valid <= (state == S_MAC);
      out_valid  <= (state == S_DRAIN);
      case (state)
        S_IDLE: begin
          if (start) begin
            in_idx <= '0;
            w_idx  <= '0;
            nrn    <= '0;
          end
        end
        S_MAC: begin
          if (!last_input) begin
            in_idx <= in_idx + IW'(1);
            w_idx  <= w_idx + WW'(1);
          end
        end
        S_DRAIN: begin
          out_index <= nrn;
          out_data  <= mac_result;
        end
        S_WRITE: begin
          if (!last_neuron) begin
            nrn    <= nrn + NW'(1);
            in_idx <= '0;
            w_idx  <= w_idx + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  mac_accumulator #(
    .RESOLUTION (RESOLUTION),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clear),
    .enable (prod_valid),
    .a      (in_data),
    .b      (w_data),
    .bias   (b_data),
    .result (mac_result)
  );

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed self-checking bench for layer_sequencer with N=4 inputs, M=2 neurons,
// backed by one-cycle-latency memory models.
module tb_layer_sequencer;

  localparam int N = 4;
  localparam int M = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [1:0]        in_addr;
  logic signed [7:0] in_data;
  logic [2:0]        w_addr;
  logic signed [7:0] w_data;
  logic [0:0]        b_addr;
  logic signed [7:0] b_data;
  logic              out_valid;
  logic [0:0]        out_index;
  logic signed [7:0] out_data;

  logic signed [7:0] in_mem [N];
  logic signed [7:0] w_mem  [N*M];
  logic signed [7:0] b_mem  [M];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layer_sequencer #(
    .NUM_INPUTS  (N),
    .NUM_NEURONS (M),
    .RESOLUTION  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_data  (out_data)
  );

  always @(posedge clk) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr];
    b_data  <= b_mem[b_addr];
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int iv, input int w0, input int w1, input int b0, input int b1);
    for (int i = 0; i < N; i++) begin
      in_mem[i]   = 8'(iv);
      w_mem[i]    = 8'(w0);
      w_mem[N+i]  = 8'(w1);
    end
    b_mem[0] = 8'(b0);
    b_mem[1] = 8'(b1);
  endtask

  // Starts a run (edge 0), follows cycles 1..16 and checks result timing,
  // indices, data and done; 'pulse' re-raises start during that cycle.
  task automatic run_layer(input string tag, input int e0, input int e1, input int pulse);
    int vcnt = 0;
    int dcnt = 0;
    int dcyc = -1;
    int vcyc [2] = '{-1, -1};
    int vidx [2] = '{-1, -1};
    int vdat [2] = '{0, 0};
    int busy1 = 0;
    int busy13 = 0;
    int busy14 = 1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start = (k == pulse);
      if (out_valid) begin
        if (vcnt < 2) begin
          vcyc[vcnt] = k;
          vidx[vcnt] = int'(out_index);
          vdat[vcnt] = int'(out_data);
        end
        vcnt++;
      end
      if (done) begin
        dcnt++;
        dcyc = k;
      end
      if (k == 1)  busy1  = int'(busy);
      if (k == 13) busy13 = int'(busy);
      if (k == 14) busy14 = int'(busy);
    end
    check({tag, "_valid_count"}, vcnt, 2);
    check({tag, "_v0_cycle"}, vcyc[0], N + 2);
    check({tag, "_v0_index"}, vidx[0], 0);
    check({tag, "_v0_data"}, vdat[0], e0);
    check({tag, "_v1_cycle"}, vcyc[1], 2 * (N + 2));
    check({tag, "_v1_index"}, vidx[1], 1);
    check({tag, "_v1_data"}, vdat[1], e1);
    check({tag, "_done_count"}, dcnt, 1);
    check({tag, "_done_cycle"}, dcyc, 1 + M * (N + 2));
    check({tag, "_busy_c1"}, busy1, 1);
    check({tag, "_busy_c13"}, busy13, 1);
    check({tag, "_busy_c14"}, busy14, 0);
  endtask

  initial begin
    int vseen;
    int dseen;
    reset = 1'b1;
    start = 1'b0;
    fill(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_addr", int'(in_addr), 0);
    check("reset_w_addr", int'(w_addr), 0);
    check("reset_b_addr", int'(b_addr), 0);
    check("reset_out_index", int'(out_index), 0);
    check("reset_out_data", int'(out_data), 0);
    reset = 1'b0;
    @(negedge clk);

    // 4*10*3 + 5 = 125 for both neurons
    fill(10, 3, 3, 5, 5);
    run_layer("basic", 125, 125, -1);

    // neuron 1: 4*10*4 + 5 = 165 -> 127
    fill(10, 3, 4, 5, 5);
    run_layer("pos_sat", 125, 127, -1);

    // 4*100*(-100) = -40000 -> -128
    fill(100, -100, -100, 0, 0);
    run_layer("neg_sat", -128, -128, -1);

    // 4*2*1 - 20 = -12
    fill(2, 1, 1, -20, -20);
    run_layer("neg_bias", -12, -12, -1);

    // distinct per-address values: n0 = 1+4+9+16+7 = 37, n1 = -1+0+6+20-3 = 22
    in_mem = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    w_mem  = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, -8'sd1, 8'sd0, 8'sd2, 8'sd5};
    b_mem  = '{8'sd7, -8'sd3};
    run_layer("addr_map", 37, 22, -1);

    fill(10, 3, 3, 5, 5);
    run_layer("start_busy", 125, 125, 3);

    // reset asserted during cycle 8 of a run
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 8) reset = 1'b1;
    end
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_addr", int'(in_addr), 0);
    check("midrst_w_addr", int'(w_addr), 0);
    check("midrst_b_addr", int'(b_addr), 0);
    check("midrst_out_index", int'(out_index), 0);
    check("midrst_out_data", int'(out_data), 0);
    reset = 1'b0;
    vseen = 0;
    dseen = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (out_valid) vseen++;
      if (done) dseen++;
    end
    check("midrst_no_valid", vseen, 0);
    check("midrst_no_done", dseen, 0);
    run_layer("after_rst", 125, 125, -1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
